// File: rtl/poarta_logica_pipe.sv
// Elastic bitwise-logic pipeline: result computed at accept, carried through STAGES valid/ready
// registers with bubble collapse. Define POARTA_CNT_EN to add the nr_op delivery counter.
module poarta_logica_pipe #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] intrare1,
   input  logic [WIDTH-1:0] intrare2,
   input  logic [2:0]       op,
   input  logic             valid_in,
   output logic             ready_in,
   output logic [WIDTH-1:0] iesire,
   output logic             valid_out,
`ifdef POARTA_CNT_EN
   output logic [15:0]      nr_op,
`endif
   input  logic             ready_out
);

   localparam int unsigned LastStg = STAGES - 1;

   logic [WIDTH-1:0]  w_result;
   logic [STAGES-1:0] w_adv;
   logic              w_acc;
   logic              w_full;

   logic [STAGES-1:0] r_valid;
   logic [WIDTH-1:0]  r_data [STAGES];

   always_comb begin
      w_result = '0;
      unique case (op)
         3'b000:  w_result = ~(intrare1 & intrare2);
         3'b001:  w_result = intrare1 & intrare2;
         3'b010:  w_result = intrare1 | intrare2;
         3'b011:  w_result = ~(intrare1 | intrare2);
         3'b100:  w_result = intrare1 ^ intrare2;
         3'b101:  w_result = ~(intrare1 ^ intrare2);
         3'b110:  w_result = ~intrare1;
         default: w_result = intrare1;
      endcase
   end

   // Stage i may advance unless it and every later stage are full while ready_out is low.
   always_comb begin
      w_full = 1'b1;
      w_adv  = '0;
      for (int i = int'(LastStg); i >= 0; i--) begin
         w_full   = w_full & r_valid[i];
         w_adv[i] = ready_out | ~w_full;
      end
   end

   assign ready_in  = ~rst & w_adv[0];
   assign w_acc     = valid_in & ready_in;
   assign valid_out = r_valid[LastStg] & ~rst;
   assign iesire    = rst ? '0 : r_data[LastStg];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         for (int i = 0; i < int'(STAGES); i++) begin
            r_data[i] <= '0;
         end
      end else begin
         if (w_adv[0]) begin
            r_valid[0] <= w_acc;
            if (w_acc) begin
               r_data[0] <= w_result;
            end
         end
         for (int i = 1; i < int'(STAGES); i++) begin
            if (w_adv[i]) begin
               r_valid[i] <= r_valid[i-1];
               r_data[i]  <= r_data[i-1];
            end
         end
      end
   end

`ifdef POARTA_CNT_EN
   logic [15:0] r_nr_op;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_nr_op <= '0;
      end else if (valid_out && ready_out && (r_nr_op != 16'hFFFF)) begin
         r_nr_op <= r_nr_op + 16'd1;
      end
   end

   assign nr_op = r_nr_op;
`endif

endmodule
